// File: rtl/napalm_pkg.sv
// rtl/napalm_pkg.sv - shared constants and types for the fetch front end
// Purpose: word size, reset fetch address, fetch state encoding, pc step.
// Ports: none (package).
package napalm_pkg;

   localparam int              XLEN             = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] WORD_INC         = 32'd4;

   typedef enum logic {
      FETCH = 1'b0,
      FLUSH = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO used for prefetch data and pc tags
// Purpose: DEPTH x WIDTH queue with same-cycle push/pop and a flush that
//          empties it.
// Ports:
//    clk, rst    clock, asynchronous active-high reset
//    i_push      write i_data (dropped when full and not popping)
//    i_data      write data
//    i_pop       remove head entry (ignored when empty)
//    i_flush     discard all entries; overrides push/pop
//    o_data      head entry (undefined when empty)
//    o_full      DEPTH entries held
//    o_empty     no entries held
//    o_count     number of entries held
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A full FIFO may still take a push when the head leaves in the same cycle.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(i_push && !i_flush && o_full && !i_pop));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with prefetch FIFO
// Purpose: issues word fetches to an in-order variable-latency memory,
//          queues {pc, inst} pairs, hands them out by valid/ready, and
//          restarts on redirect while dropping responses still in flight.
// Ports:
//    clk, rst                      clock, asynchronous active-high reset
//    redirect, redirect_pc         flush and restart at redirect_pc (word aligned)
//    imem_req, imem_addr           request valid / word address
//    imem_gnt                      request accepted
//    imem_rvalid, imem_rdata       in-order response
//    out_valid, out_ready          instruction handshake to the core
//    out_pc, out_inst              head {pc, inst}
module fetch_unit
   import napalm_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_inst
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t    r_state;
   fetch_state_t    w_state_nxt;
   logic [XLEN-1:0] r_fetch_pc;
   logic [CW-1:0]   r_inflight;
   logic [CW-1:0]   r_stale;
   logic [CW-1:0]   w_stale_nxt;
   logic [CW-1:0]   w_outstanding;
   logic [CW-1:0]   w_credits;
   logic [CW-1:0]   w_fifo_count;
   logic [CW-1:0]   w_tag_count;
   logic            w_fifo_empty;
   logic            w_fifo_full;
   logic            w_tag_empty;
   logic            w_tag_full;
   logic [2*XLEN-1:0] w_head;
   logic [XLEN-1:0] w_tag_pc;
   logic [XLEN-1:0] w_redirect_word;
   logic            w_gnt_fire;
   logic            w_resp_fire;
   logic            w_pop;

   assign w_redirect_word = redirect_pc & ~32'h3;
   assign w_credits       = CW'(DEPTH) - w_fifo_count - r_inflight;
   assign w_outstanding   = r_stale + r_inflight;
   assign w_gnt_fire      = imem_req && imem_gnt;
   // Only live (non-stale) responses with a matching tag enter the FIFO.
   assign w_resp_fire     = imem_rvalid && (r_stale == '0) && (r_inflight != '0) && !redirect;
   assign w_pop           = !w_fifo_empty && out_ready && !redirect;

   // Stale bookkeeping. On redirect everything outstanding becomes stale,
   // less one if a response lands in that same cycle.
   always_comb begin
      w_stale_nxt = r_stale;
      if (redirect) begin
         w_stale_nxt = w_outstanding;
         if (imem_rvalid && w_outstanding != '0) w_stale_nxt = w_outstanding - CW'(1);
      end else if (imem_rvalid && r_stale != '0) begin
         w_stale_nxt = r_stale - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_inflight <= '0;
         r_stale    <= '0;
      end else begin
         r_stale <= w_stale_nxt;
         if (redirect) begin
            r_fetch_pc <= w_redirect_word;
            r_inflight <= '0;
         end else begin
            if (w_gnt_fire) r_fetch_pc <= r_fetch_pc + WORD_INC;
            r_inflight <= r_inflight + CW'(w_gnt_fire) - CW'(w_resp_fire);
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= FETCH;
      else     r_state <= w_state_nxt;
   end

   // Next state: FLUSH exactly while stale responses remain to be drained.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FETCH: if (redirect && w_stale_nxt != '0) w_state_nxt = FLUSH;
         FLUSH: if (w_stale_nxt == '0) w_state_nxt = FETCH;
         default: w_state_nxt = FETCH;
      endcase
   end

   // Outputs; rst gates imem_req so it drops the moment reset asserts.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = r_fetch_pc;
      out_valid = 1'b0;
      out_pc    = '0;
      out_inst  = '0;
      if (!rst && r_state == FETCH && w_credits != '0 && !redirect) imem_req = 1'b1;
      if (!w_fifo_empty) begin
         out_valid = 1'b1;
         out_pc    = w_head[2*XLEN-1:XLEN];
         out_inst  = w_head[XLEN-1:0];
      end
   end

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag_q (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_gnt_fire),
      .i_data  (r_fetch_pc),
      .i_pop   (w_resp_fire),
      .i_flush (redirect),
      .o_data  (w_tag_pc),
      .o_full  (w_tag_full),
      .o_empty (w_tag_empty),
      .o_count (w_tag_count)
   );

   fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_out_q (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_resp_fire),
      .i_data  ({w_tag_pc, imem_rdata}),
      .i_pop   (w_pop),
      .i_flush (redirect),
      .o_data  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
      !(imem_rvalid && w_outstanding == '0));
   a_tag_tracks_inflight: assert property (@(posedge clk) disable iff (rst)
      w_tag_count == r_inflight);
   a_tag_not_full_on_gnt: assert property (@(posedge clk) disable iff (rst)
      !(w_gnt_fire && w_tag_full));
   a_tag_present_on_resp: assert property (@(posedge clk) disable iff (rst)
      !(w_resp_fire && w_tag_empty));
   a_fifo_room_on_resp: assert property (@(posedge clk) disable iff (rst)
      !(w_resp_fire && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
// Purpose: per-cycle vector table for streaming and back-pressure, plus
//          hand-written redirect, flush and async-reset sequences against
//          an in-order memory model with configurable latency.
// Ports: none (top-level bench).
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int lat   = 1;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } pend_t;
   pend_t pend[$];

   typedef struct {
      bit          do_reset;
      bit          ready;
      bit          exp_req;
      logic [31:0] exp_addr;
      bit          exp_valid;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t tbl[$];

   fetch_unit #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_inst    (out_inst)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, a[15:0]};
   endfunction

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drive_resp();
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(pend[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
   endtask

   // Called settled within a cycle; returns at edge+1 of the next cycle.
   task automatic step();
      logic        g;
      logic        rv;
      logic [31:0] a;
      g  = imem_req && imem_gnt;
      rv = imem_rvalid;
      a  = imem_addr;
      @(posedge clk);
      #1;
      if (rv && pend.size() > 0) void'(pend.pop_front());
      if (g) pend.push_back('{cyc + lat, a});
      cyc++;
      drive_resp();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect = 1'b0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = '0;
      out_ready = 1'b0;
      pend.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk32("rst_req",   {31'b0, imem_req},  32'd0);
      chk32("rst_addr",  imem_addr,          RST_PC);
      chk32("rst_valid", {31'b0, out_valid}, 32'd0);
      chk32("rst_pc",    out_pc,             32'd0);
      chk32("rst_inst",  out_inst,           32'd0);
      rst = 1'b0;
      cyc = 1;
   endtask

   task automatic wait_first(input string nm, input logic [31:0] exp_pc, input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         settle();
         if (out_valid) begin
            found = 1'b1;
            chk32({nm, "_pc"},   out_pc,   exp_pc);
            chk32({nm, "_inst"}, out_inst, mem_word(exp_pc));
         end
         step();
      end
      if (!found) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: no out_valid within %0d cycles, expected pc %h", nm, budget, exp_pc);
      end
   endtask

   initial begin
      // Stream, out_ready=1, grant every cycle, 1-cycle response.
      tbl.push_back('{1, 1, 1, 32'h00, 0, 32'h00});
      tbl.push_back('{0, 1, 1, 32'h04, 0, 32'h00});
      tbl.push_back('{0, 1, 1, 32'h08, 1, 32'h00});
      tbl.push_back('{0, 1, 1, 32'h0C, 1, 32'h04});
      tbl.push_back('{0, 1, 1, 32'h10, 1, 32'h08});
      tbl.push_back('{0, 1, 1, 32'h14, 1, 32'h0C});
      tbl.push_back('{0, 1, 1, 32'h18, 1, 32'h10});
      tbl.push_back('{0, 1, 1, 32'h1C, 1, 32'h14});
      // Back-pressure: out_ready=0 for 10 cycles, then released.
      tbl.push_back('{1, 0, 1, 32'h00, 0, 32'h00});
      tbl.push_back('{0, 0, 1, 32'h04, 0, 32'h00});
      tbl.push_back('{0, 0, 1, 32'h08, 1, 32'h00});
      tbl.push_back('{0, 0, 1, 32'h0C, 1, 32'h00});
      for (int i = 0; i < 6; i++) tbl.push_back('{0, 0, 0, 32'h10, 1, 32'h00});
      tbl.push_back('{0, 1, 0, 32'h10, 1, 32'h00});
      tbl.push_back('{0, 1, 1, 32'h10, 1, 32'h04});
      tbl.push_back('{0, 1, 1, 32'h14, 1, 32'h08});
      tbl.push_back('{0, 1, 1, 32'h18, 1, 32'h0C});
      tbl.push_back('{0, 1, 1, 32'h1C, 1, 32'h10});

      lat = 1;
      foreach (tbl[i]) begin
         if (tbl[i].do_reset) do_reset();
         out_ready = tbl[i].ready;
         imem_gnt  = 1'b1;
         settle();
         chk32($sformatf("vec%0d_req", i),   {31'b0, imem_req},  {31'b0, tbl[i].exp_req});
         chk32($sformatf("vec%0d_addr", i),  imem_addr,          tbl[i].exp_addr);
         chk32($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].exp_valid});
         if (tbl[i].exp_valid) begin
            chk32($sformatf("vec%0d_pc", i),   out_pc,   tbl[i].exp_pc);
            chk32($sformatf("vec%0d_inst", i), out_inst, mem_word(tbl[i].exp_pc));
         end
         step();
      end

      // Latency 3, redirect to 0x100 with 3 in flight (one returning now).
      do_reset();
      lat = 3; imem_gnt = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin settle(); step(); end
      redirect = 1'b1; redirect_pc = 32'h100;
      settle();
      chk32("a_redir_req", {31'b0, imem_req}, 32'd0);
      step();
      redirect = 1'b0;
      settle(); chk32("a_flush_req_c5", {31'b0, imem_req}, 32'd0);
      chk32("a_flush_valid_c5", {31'b0, out_valid}, 32'd0); step();
      settle(); chk32("a_flush_req_c6", {31'b0, imem_req}, 32'd0); step();
      settle();
      chk32("a_resume_req",  {31'b0, imem_req}, 32'd1);
      chk32("a_resume_addr", imem_addr,         32'h100);
      wait_first("a_first", 32'h100, 20);
      settle();
      chk32("a_second_valid", {31'b0, out_valid}, 32'd1);
      chk32("a_second_pc",    out_pc,             32'h104);
      step();

      // Redirect to 0x203 together with a pop and a live rvalid.
      do_reset();
      lat = 1; imem_gnt = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin settle(); step(); end
      redirect = 1'b1; redirect_pc = 32'h203;
      settle();
      chk32("b_pre_pc",     out_pc,               32'h04);
      chk32("b_pre_rvalid", {31'b0, imem_rvalid}, 32'd1);
      step();
      redirect = 1'b0;
      settle();
      chk32("b_req",   {31'b0, imem_req},  32'd1);
      chk32("b_addr",  imem_addr,          32'h200);
      chk32("b_valid", {31'b0, out_valid}, 32'd0);
      step();
      settle(); chk32("b_valid_c6", {31'b0, out_valid}, 32'd0); step();
      settle();
      chk32("b_valid_c7", {31'b0, out_valid}, 32'd1);
      chk32("b_pc_c7",    out_pc,             32'h200);
      chk32("b_inst_c7",  out_inst,           mem_word(32'h200));
      step();

      // Two redirects during FLUSH: 0x40 then 0x80.
      do_reset();
      lat = 3; imem_gnt = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin settle(); step(); end
      redirect = 1'b1; redirect_pc = 32'h40;
      settle(); step();
      redirect_pc = 32'h80;
      settle(); step();
      redirect = 1'b0;
      settle(); chk32("c_flush_req_c6", {31'b0, imem_req}, 32'd0); step();
      settle();
      chk32("c_resume_req",  {31'b0, imem_req}, 32'd1);
      chk32("c_resume_addr", imem_addr,         32'h80);
      wait_first("c_first", 32'h80, 20);

      // Asynchronous reset between edges in the middle of a burst.
      do_reset();
      lat = 1; imem_gnt = 1'b1; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin settle(); step(); end
      settle();
      chk32("d_pre_valid", {31'b0, out_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk32("d_async_valid", {31'b0, out_valid}, 32'd0);
      chk32("d_async_req",   {31'b0, imem_req},  32'd0);
      do_reset();
      settle();
      chk32("d_post_req",  {31'b0, imem_req}, 32'd1);
      chk32("d_post_addr", imem_addr,         RST_PC);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end. Sits directly upstream of the core's instruction path and supplies {pc, inst} pairs that the core decodes.
- Drives a variable-latency, in-order instruction-memory request/grant/response interface.
- Keeps requests in flight into a small prefetch FIFO, then hands out one instruction per valid/ready transfer.
- Accepts a redirect (branch/jump target from the branch unit) that flushes the FIFO and discards stale responses still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, prefetch FIFO entries; also the maximum number of outstanding requests. Power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- imem_req  out  1  request valid
- imem_addr  out  32  word-aligned request address
- imem_gnt  in  1  request accepted this cycle (only meaningful while imem_req=1)
- imem_rvalid  in  1  response valid; in order, at least 1 cycle after its gnt
- imem_rdata  in  32  response instruction word
- out_valid  out  1  out_pc/out_inst valid
- out_ready  in  1  core consumes the entry this cycle
- out_pc  out  32  address of out_inst
- out_inst  out  32  instruction word

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, FIFO empty, inflight=0, stale=0, state=FETCH.
  - Output reset values: out_valid=0, out_pc=0, out_inst=0, imem_req=0, imem_addr=RESET_PC.
- Credits = DEPTH - fifo_count - inflight.
- imem_req = (state==FETCH) && credits>0 && !redirect. Combinational. imem_addr = fetch_pc.
- On imem_req && imem_gnt:
  - fetch_pc += 4, wrapping mod 2^32.
  - inflight += 1.
  - The granted pc is pushed into an internal pc tag queue of depth DEPTH.
- On imem_rvalid with stale>0: stale -= 1; data dropped.
- On imem_rvalid with stale==0:
  - {tag_pc, imem_rdata} is written to the FIFO; inflight -= 1.
  - The entry becomes visible on out_* the following cycle.
  - No bypass: minimum gnt-to-out_valid latency is 2 cycles.
- rvalid with no request outstanding is a protocol violation: ignored, and flagged by an assertion.
- Pop: out_valid && out_ready removes the head entry. A push and a pop in the same cycle are both honoured. FIFO pointers wrap modulo DEPTH.
- The credit rule guarantees the FIFO never overflows. A push into a full FIFO is an assertion failure.
- out_valid = FIFO not empty. out_pc/out_inst come from the head entry and are held stable while out_valid && !out_ready.
- Redirect (sampled at a clock edge, highest priority):
  - FIFO emptied; any simultaneous pop and rvalid in that cycle are discarded.
  - stale += inflight (including an rvalid arriving in the same cycle: it is consumed as stale); inflight=0.
  - Tag queue cleared; fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Next state = FLUSH if the resulting stale>0, else FETCH.
- State machine:
  - FETCH: issue requests per the credit rule.
  - FLUSH: imem_req=0; leave for FETCH in the cycle after stale reaches 0.
  - A redirect in FLUSH updates fetch_pc and keeps the stale count; the last redirect wins.
- Redirect timing:
  - With nothing in flight: imem_req at the new address in cycle N+1.
  - First out_valid no earlier than N+3, with a 1-cycle grant/response.
- Reset mid-operation: all state is abandoned immediately. The memory side must also be reset, so no stale-response tracking carries across reset.
- Counter widths: inflight and stale are $clog2(DEPTH)+1 bits; stale never exceeds DEPTH.

Decomposition:
- Shared package (napalm_pkg):
  - XLEN=32 and RESET_PC default.
  - Fetch state enum {FETCH, FLUSH}.
  - Word-increment constant 4.
- One sub-module: fetch_fifo.
  - Parameterised DEPTH × 64-bit synchronous FIFO with push, pop, flush, full, empty and count.
  - Used for the output queue.
- The pc tag queue is a second instance with width 32.

Test Plan:
- Reset release, memory grants every cycle, response 1 cycle later, out_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8…
  - out_valid first in cycle 3.
  - out_pc/out_inst pairs match the memory image, one per cycle.
- out_ready=0 for 10 cycles, DEPTH=4:
  - Exactly 4 grants taken, then imem_req=0.
  - out_pc=0x0 held stable.
  - Releasing out_ready resumes at 0x10.
- Response latency 3, redirect to 0x100 with 3 in flight:
  - State FLUSH, 3 responses dropped.
  - imem_req reasserts after the 3rd stale rvalid.
  - First out_pc=0x100, and no 0x0–0x8 data appears after the redirect.
- Redirect with redirect_pc=0x203, simultaneous with pop and rvalid:
  - Next imem_addr=0x200.
  - Popped and returned entries discarded; out_valid=0 the next cycle.
- Two redirects during FLUSH (0x40, then 0x80): fetch resumes at 0x80 only, and stale count stays correct.
- rst asserted mid-burst (asynchronously, between edges): out_valid=0 and imem_req=0 immediately; after release the first imem_addr=RESET_PC.
